// File: rtl/apb_cmd_master_pkg.sv
// Shared types and default widths for the APB command master.
package apb_cmd_master_pkg;

  localparam int ADDR_WD_DEF     = 8;
  localparam int DATA_WD_DEF     = 6;
  localparam int STRB_WD_DEF     = 2;
  localparam int PROT_WD_DEF     = 4;
  localparam int TIMEOUT_CYC_DEF = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef struct packed {
    logic                   write;
    logic [ADDR_WD_DEF-1:0] addr;
    logic [DATA_WD_DEF-1:0] wdata;
    logic [STRB_WD_DEF-1:0] strb;
    logic [PROT_WD_DEF-1:0] prot;
  } cmd_t;

endpackage

// File: rtl/apb_cmd_wdog.sv
// ACCESS-phase watchdog for apb_cmd_master; only instantiated when
// APB_CMD_MASTER_TIMEOUT_EN is defined.
module apb_cmd_wdog #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic a_pclk,
  input  logic a_prst_n,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int CNT_WD = $clog2(TIMEOUT_CYC) + 1;

  logic [CNT_WD-1:0] cnt;

  always_ff @(posedge a_pclk or negedge a_prst_n) begin
    if (!a_prst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Fires on the stalled cycle whose increment would reach the limit.
  assign expire = inc && (cnt == CNT_WD'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/apb_cmd_master.sv
// APB4 requester: one valid/ready command -> one APB transfer -> one response.
// Optional ACCESS timeout enabled by defining APB_CMD_MASTER_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | psel=1, penable=0 for one cycle
// ACCESS | psel=1, penable=1 until pready (or timeout)
// RESP   | rsp_valid high until rsp_ready
module apb_cmd_master
  import apb_cmd_master_pkg::*;
#(
  parameter int ADDR_WD     = ADDR_WD_DEF,
  parameter int DATA_WD     = DATA_WD_DEF,
  parameter int STRB_WD     = STRB_WD_DEF,
  parameter int PROT_WD     = PROT_WD_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic               a_pclk,
  input  logic               a_prst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [ADDR_WD-1:0] cmd_addr,
  input  logic [DATA_WD-1:0] cmd_wdata,
  input  logic [STRB_WD-1:0] cmd_strb,
  input  logic [PROT_WD-1:0] cmd_prot,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_write,
  output logic [DATA_WD-1:0] rsp_rdata,
  output logic               rsp_err,
  output logic               a_psel,
  output logic               a_penable,
  output logic               a_pwrite,
  output logic [ADDR_WD-1:0] a_paddr,
  output logic [DATA_WD-1:0] a_pwdata,
  output logic [PROT_WD-1:0] a_pprot,
  output logic [STRB_WD-1:0] a_pstrb,
  input  logic [DATA_WD-1:0] a_prdata,
  input  logic               a_pready
);

  state_t state;
  logic   tmo_hit;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("apb_cmd_master: TIMEOUT_CYC must be at least 1");
  end

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  apb_cmd_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .a_pclk   (a_pclk),
    .a_prst_n (a_prst_n),
    .clr      (state == SETUP),
    .inc      ((state == ACCESS) && !a_pready),
    .expire   (tmo_hit)
  );
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge a_pclk or negedge a_prst_n) begin
    if (!a_prst_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      a_psel    <= 1'b0;
      a_penable <= 1'b0;
      a_pwrite  <= 1'b0;
      a_paddr   <= '0;
      a_pwdata  <= '0;
      a_pprot   <= '0;
      a_pstrb   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            a_psel    <= 1'b1;
            a_pwrite  <= cmd_write;
            a_paddr   <= cmd_addr;
            a_pwdata  <= cmd_wdata;
            a_pprot   <= cmd_prot;
            a_pstrb   <= cmd_write ? cmd_strb : '0;
            state     <= SETUP;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        SETUP: begin
          a_penable <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          // pready wins over a coincident timeout
          if (a_pready || tmo_hit) begin
            a_psel    <= 1'b0;
            a_penable <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_write <= a_pwrite;
            rsp_rdata <= (a_pready && !a_pwrite) ? a_prdata : '0;
            rsp_err   <= !a_pready;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: directed vector table, hand-written
// corner sequences and a randomized write/read stream against a memory model.
module tb_apb_cmd_master;
  import apb_cmd_master_pkg::*;

  logic       a_pclk = 1'b0;
  logic       a_prst_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [7:0] cmd_addr = '0;
  logic [5:0] cmd_wdata = '0;
  logic [1:0] cmd_strb = '0;
  logic [3:0] cmd_prot = '0;
  logic       rsp_valid, rsp_ready = 1'b0, rsp_write, rsp_err;
  logic [5:0] rsp_rdata;
  logic       a_psel, a_penable, a_pwrite;
  logic [7:0] a_paddr;
  logic [5:0] a_pwdata;
  logic [3:0] a_pprot;
  logic [1:0] a_pstrb;
  logic [5:0] a_prdata = '0;
  logic       a_pready = 1'b0;

  apb_cmd_master dut (
    .a_pclk(a_pclk), .a_prst_n(a_prst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .a_psel(a_psel), .a_penable(a_penable), .a_pwrite(a_pwrite), .a_paddr(a_paddr),
    .a_pwdata(a_pwdata), .a_pprot(a_pprot), .a_pstrb(a_pstrb),
    .a_prdata(a_prdata), .a_pready(a_pready)
  );

  always #5 a_pclk = ~a_pclk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0] ref_mem [256];   // expected contents, from commands
  logic [5:0] slv_mem [256];   // slave contents, from observed APB traffic
  logic [5:0] last_rdata;

  typedef struct {
    cmd_t       c;
    int         waits;
    logic [5:0] exp_rdata;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] merge(input logic [5:0] old, input logic [5:0] d,
                                       input logic [1:0] s);
    logic [5:0] r;
    r = old;
    if (s[0]) r[2:0] = d[2:0];
    if (s[1]) r[5:3] = d[5:3];
    return r;
  endfunction

  task automatic check_all_zero(input string nm);
    check({nm, "_cmd_ready"}, 32'(cmd_ready), 0);
    check({nm, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({nm, "_rsp_write"}, 32'(rsp_write), 0);
    check({nm, "_rsp_rdata"}, 32'(rsp_rdata), 0);
    check({nm, "_rsp_err"},   32'(rsp_err), 0);
    check({nm, "_psel"},      32'(a_psel), 0);
    check({nm, "_penable"},   32'(a_penable), 0);
    check({nm, "_pwrite"},    32'(a_pwrite), 0);
    check({nm, "_paddr"},     32'(a_paddr), 0);
    check({nm, "_pwdata"},    32'(a_pwdata), 0);
    check({nm, "_pprot"},     32'(a_pprot), 0);
    check({nm, "_pstrb"},     32'(a_pstrb), 0);
  endtask

  task automatic check_bus(input string nm, input cmd_t c, input logic sel, input logic en);
    check({nm, "_psel"},    32'(a_psel), 32'(sel));
    check({nm, "_penable"}, 32'(a_penable), 32'(en));
    check({nm, "_pwrite"},  32'(a_pwrite), 32'(c.write));
    check({nm, "_paddr"},   32'(a_paddr), 32'(c.addr));
    check({nm, "_pwdata"},  32'(a_pwdata), 32'(c.wdata));
    check({nm, "_pprot"},   32'(a_pprot), 32'(c.prot));
    check({nm, "_pstrb"},   32'(a_pstrb), c.write ? 32'(c.strb) : 0);
    check({nm, "_cmd_ready"}, 32'(cmd_ready), 0);
    check({nm, "_rsp_valid"}, 32'(rsp_valid), 0);
  endtask

  // Entered at a negedge in IDLE; returns at the negedge after the rsp handshake.
  task automatic xfer(input cmd_t c, input int waits, input int hold, input bit pend);
    logic [5:0] exp_rd;
    exp_rd = c.write ? 6'h00 : ref_mem[c.addr];
    if (c.write) ref_mem[c.addr] = merge(ref_mem[c.addr], c.wdata, c.strb);
    cmd_valid = 1'b1; cmd_write = c.write; cmd_addr = c.addr;
    cmd_wdata = c.wdata; cmd_strb = c.strb; cmd_prot = c.prot;
    rsp_ready = 1'b0; a_pready = 1'($urandom); a_prdata = 6'($urandom);
    check("idle_cmd_ready", 32'(cmd_ready), 1);
    check("idle_psel", 32'(a_psel), 0);
    @(negedge a_pclk);
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 8'($urandom);
    cmd_wdata = 6'($urandom); cmd_strb = 2'($urandom); cmd_prot = 4'($urandom);
    check_bus("setup", c, 1'b1, 1'b0);
    a_pready = 1'($urandom);
    for (int i = 0; i <= waits; i++) begin
      @(negedge a_pclk);
      check_bus("access", c, 1'b1, 1'b1);
      a_pready = (i == waits);
      a_prdata = 6'($urandom);
      if (i == waits) begin
        if (a_pwrite) slv_mem[a_paddr] = merge(slv_mem[a_paddr], a_pwdata, a_pstrb);
        else          a_prdata = slv_mem[a_paddr];
      end
    end
    for (int h = 0; h <= hold; h++) begin
      @(negedge a_pclk);
      a_pready = 1'($urandom); a_prdata = 6'($urandom);
      if (h == 0) last_rdata = rsp_rdata;
      check("resp_psel",      32'(a_psel), 0);
      check("resp_penable",   32'(a_penable), 0);
      check("resp_valid",     32'(rsp_valid), 1);
      check("resp_write",     32'(rsp_write), 32'(c.write));
      check("resp_rdata",     32'(rsp_rdata), 32'(exp_rd));
      check("resp_err",       32'(rsp_err), 0);
      check("resp_cmd_ready", 32'(cmd_ready), 0);
      if (pend) cmd_valid = 1'b1;
      rsp_ready = (h == hold);
    end
    @(negedge a_pclk);
    rsp_ready = 1'b0;
    check("post_rsp_valid", 32'(rsp_valid), 0);
    check("post_cmd_ready", 32'(cmd_ready), 1);
    check("post_psel",      32'(a_psel), 0);
    check("post_paddr_hold", 32'(a_paddr), 32'(c.addr));
  endtask

  always @(negedge a_pclk)
    if (a_prst_n && a_penable && !a_psel) check("penable_without_psel", 32'(a_penable), 0);

  vec_t vecs[13];

  initial begin
    cmd_t c;
    int   n_acc;

    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = '0;
      slv_mem[i] = '0;
    end
    vecs[0]  = '{'{1'b1, 8'h3C, 6'h2A, 2'b11, 4'h2}, 0, 6'h00};
    vecs[1]  = '{'{1'b0, 8'h3C, 6'h11, 2'b11, 4'h0}, 0, 6'h2A};
    vecs[2]  = '{'{1'b1, 8'h81, 6'h15, 2'b11, 4'h5}, 1, 6'h00};
    vecs[3]  = '{'{1'b0, 8'h81, 6'h00, 2'b10, 4'h1}, 3, 6'h15};
    vecs[4]  = '{'{1'b1, 8'h3C, 6'h3F, 2'b01, 4'h0}, 2, 6'h00};
    vecs[5]  = '{'{1'b0, 8'h3C, 6'h3F, 2'b01, 4'h3}, 0, 6'h2F};
    vecs[6]  = '{'{1'b1, 8'h3C, 6'h00, 2'b10, 4'h0}, 0, 6'h00};
    vecs[7]  = '{'{1'b0, 8'h3C, 6'h00, 2'b00, 4'h0}, 1, 6'h07};
    vecs[8]  = '{'{1'b1, 8'h3C, 6'h3F, 2'b00, 4'h0}, 0, 6'h00};
    vecs[9]  = '{'{1'b0, 8'h3C, 6'h00, 2'b00, 4'h0}, 0, 6'h07};
    vecs[10] = '{'{1'b0, 8'h55, 6'h2B, 2'b11, 4'hA}, 2, 6'h00};
    vecs[11] = '{'{1'b1, 8'hFF, 6'h3F, 2'b11, 4'hF}, 4, 6'h00};
    vecs[12] = '{'{1'b0, 8'hFF, 6'h00, 2'b00, 4'hF}, 0, 6'h3F};

    #12;
    check_all_zero("reset");
    @(negedge a_pclk);
    a_prst_n = 1'b1;
    @(negedge a_pclk);

    foreach (vecs[i]) begin
      xfer(vecs[i].c, vecs[i].waits, 0, 1'b0);
      check("vec_rdata", 32'(last_rdata), 32'(vecs[i].exp_rdata));
    end

    // Response backpressure with a second command waiting
    xfer('{1'b1, 8'h20, 6'h11, 2'b11, 4'h0}, 0, 5, 1'b1);
    xfer('{1'b0, 8'h20, 6'h00, 2'b00, 4'h0}, 0, 0, 1'b0);
    check("bp_readback", 32'(last_rdata), 32'h11);

    // Reset during ACCESS drops the transfer silently
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h81; cmd_strb = 2'b00; cmd_prot = 4'h0;
    @(negedge a_pclk);
    cmd_valid = 1'b0; a_pready = 1'b0;
    @(negedge a_pclk);
    @(negedge a_pclk);
    check("pre_rst_penable", 32'(a_penable), 1);
    #2 a_prst_n = 1'b0;
    #1 check_all_zero("mid_rst");
    @(negedge a_pclk);
    a_prst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge a_pclk);
      check("post_rst_rsp_valid", 32'(rsp_valid), 0);
      check("post_rst_psel", 32'(a_psel), 0);
    end
    xfer('{1'b0, 8'h81, 6'h00, 2'b00, 4'h0}, 1, 0, 1'b0);
    check("post_rst_readback", 32'(last_rdata), 32'h15);

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    // pready on the 64th ACCESS cycle completes normally
    xfer('{1'b0, 8'h3C, 6'h00, 2'b00, 4'h0}, 63, 0, 1'b0);
    check("tmo_edge_rdata", 32'(last_rdata), 32'h07);
    // pready never arrives
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h3C; cmd_strb = 2'b00;
    @(negedge a_pclk);
    cmd_valid = 1'b0; a_pready = 1'b0; a_prdata = 6'h3F;
    n_acc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge a_pclk);
      if (!(a_psel && a_penable)) break;
      n_acc++;
    end
    check("tmo_access_cycles", 32'(n_acc), 64);
    check("tmo_psel", 32'(a_psel), 0);
    check("tmo_rsp_valid", 32'(rsp_valid), 1);
    check("tmo_rsp_err", 32'(rsp_err), 1);
    check("tmo_rsp_rdata", 32'(rsp_rdata), 0);
    rsp_ready = 1'b1;
    @(negedge a_pclk);
    rsp_ready = 1'b0;
    check("tmo_rsp_clear", 32'(rsp_valid), 0);
`endif

    // Alternating write/read stream over a small address window
    for (int i = 0; i < 256; i++) begin
      c.write = (i % 2 == 0);
      c.addr  = 8'h40 + 8'($urandom_range(0, 15));
      c.wdata = 6'($urandom);
      c.strb  = 2'($urandom);
      c.prot  = 4'($urandom);
      xfer(c, $urandom_range(0, 4), $urandom_range(0, 2), 1'b0);
    end
    for (int a = 8'h40; a < 8'h50; a++)
      check("slave_mem_final", 32'(slv_mem[a]), 32'(ref_mem[a]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
